// File: rtl/uart_resp_pkg.sv
// Shared constants for the UART bus responder: register offsets, status bit
// positions and the TX launch FSM encoding.
package uart_resp_pkg;

    localparam logic [31:0] TXDATA_OFF = 32'd0;
    localparam logic [31:0] RXDATA_OFF = 32'd4;
    localparam logic [31:0] STAT_OFF   = 32'd8;

    localparam int ST_RX_VALID    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_BUSY     = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_OVERFLOW = 5;
    localparam int ST_RX_IRQ_EN   = 8;
    localparam int ST_TX_IRQ_EN   = 9;
    localparam int ST_LOOPBACK    = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_bus_responder_if.sv
// CPU data-bus (MEM stage) connection: single-cycle rd/wr strobes with
// combinational read data returned by the responder.
interface uart_bus_responder_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_bus_responder_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; pushes when full and pops when
// empty are ignored, and the head entry is visible combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[AW-1:0]];

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; an entry is never read before the pointers say it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped UART controller: TXDATA/RXDATA/STATUS registers, TX FIFO with
// launch FSM, RX holding register and level IRQ. Option: UART_RESP_LOOPBACK_EN.
module uart_bus_responder
    import uart_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
    parameter int          TX_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_bus_responder_if.slave  bus,
    output logic                 irqout,
    output logic                 TX_EN,
    output logic [7:0]           TX_DATA,
    input  logic                 TX_STATUS,
    input  logic                 RX_STATUS,
    input  logic [7:0]           RX_DATA
);
    tx_state_e   state;
    tx_state_e   state_next;
    logic        sel_tx, sel_rx, sel_stat;
    logic        wr_tx, wr_stat, rd_rx;
    logic        tx_full, tx_empty, tx_busy, pop;
    logic [7:0]  fifo_head;
    logic        loopback, rx_load;
    logic [7:0]  rx_in;
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_overrun, tx_overflow;
    logic        rx_irq_en, tx_irq_en;
    logic [31:0] status;
    logic        unused_wdata;

    assign sel_tx   = (bus.addr == BASE_ADDR + TXDATA_OFF);
    assign sel_rx   = (bus.addr == BASE_ADDR + RXDATA_OFF);
    assign sel_stat = (bus.addr == BASE_ADDR + STAT_OFF);
    assign wr_tx    = bus.wr && sel_tx;
    assign wr_stat  = bus.wr && sel_stat;
    assign rd_rx    = bus.rd && sel_rx;
    assign unused_wdata = ^bus.wdata[31:10];

    // A pop in LAUNCH never frees a slot for a push on the same edge.
    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx && !tx_full),
        .wdata (bus.wdata[7:0]),
        .pop   (pop),
        .head  (fifo_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!tx_empty) state_next = LAUNCH;
            LAUNCH:    state_next = loopback ? IDLE : WAIT_BUSY;
            WAIT_BUSY: if (TX_STATUS) state_next = WAIT_DONE;
            WAIT_DONE: if (!TX_STATUS) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    assign pop     = (state == LAUNCH);
    assign tx_busy = (state != IDLE);

`ifdef UART_RESP_LOOPBACK_EN
    logic loopback_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       loopback_q <= 1'b0;
        else if (wr_stat) loopback_q <= bus.wdata[ST_LOOPBACK];
    end
    assign loopback = loopback_q;
    assign rx_load  = loopback ? pop : RX_STATUS;
    assign rx_in    = loopback ? fifo_head : RX_DATA;
`else
    assign loopback = 1'b0;
    assign rx_load  = RX_STATUS;
    assign rx_in    = RX_DATA;
`endif

    // TX_EN and TX_DATA are registered off the pop edge, giving the 2-cycle launch latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            TX_EN   <= 1'b0;
            TX_DATA <= 8'h00;
        end else begin
            TX_EN <= pop && !loopback;
            if (pop && !loopback) TX_DATA <= fifo_head;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            rx_irq_en   <= 1'b0;
            tx_irq_en   <= 1'b0;
            irqout      <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_byte  <= rx_in;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (rx_load && rx_valid && !rd_rx)            rx_overrun <= 1'b1;
            else if (wr_stat && bus.wdata[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
            if (wr_tx && tx_full)                          tx_overflow <= 1'b1;
            else if (wr_stat && bus.wdata[ST_TX_OVERFLOW]) tx_overflow <= 1'b0;
            if (wr_stat) begin
                rx_irq_en <= bus.wdata[ST_RX_IRQ_EN];
                tx_irq_en <= bus.wdata[ST_TX_IRQ_EN];
            end
            irqout <= (rx_irq_en && rx_valid) || (tx_irq_en && tx_empty && !tx_busy) || rx_overrun;
        end
    end

    always_comb begin
        status                 = '0;
        status[ST_RX_VALID]    = rx_valid;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_BUSY]     = tx_busy;
        status[ST_RX_OVERRUN]  = rx_overrun;
        status[ST_TX_OVERFLOW] = tx_overflow;
        status[ST_RX_IRQ_EN]   = rx_irq_en;
        status[ST_TX_IRQ_EN]   = tx_irq_en;
        status[ST_LOOPBACK]    = loopback;
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && sel_rx)        bus.rdata = {24'h0, rx_byte};
        else if (bus.rd && sel_stat) bus.rdata = status;
    end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench: register vector table, directed TX/RX corner sequences,
// then randomized RX/CTRL/TX traffic against a register-level reference model.
module tb_uart_bus_responder;
    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] RXA  = BASE + 32'd4;
    localparam logic [31:0] STA  = BASE + 32'd8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       irqout, tx_en, tx_status, rx_status;
    logic [7:0] tx_data, rx_data;
    logic       auto_tx = 1'b0;
    logic       tx_hold = 1'b0;
    int         busy_cnt = 0;
    int         n_err = 0;
    int         n_checks = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_bus_responder_if bus ();

    uart_bus_responder #(.BASE_ADDR(BASE), .TX_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .irqout    (irqout),
        .TX_EN     (tx_en),
        .TX_DATA   (tx_data),
        .TX_STATUS (tx_status),
        .RX_STATUS (rx_status),
        .RX_DATA   (rx_data)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy for 6 cycles after each start pulse when enabled.
    always @(negedge clk) begin
        if (!auto_tx)            busy_cnt = 0;
        else if (tx_en === 1'b1) busy_cnt = 6;
        else if (busy_cnt > 0)   busy_cnt = busy_cnt - 1;
    end
    assign tx_status = auto_tx ? (busy_cnt > 0) : tx_hold;

    always @(negedge clk) if (tx_en === 1'b1) got_q.push_back(tx_data);

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rxs;
        logic [7:0]  rxd;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[13];

    // Reference model of the RX holding register and control bits.
    logic [7:0] m_byte;
    logic       m_valid, m_ovr, m_rxen;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic rxs, input logic [7:0] rxd, output logic [31:0] d);
        bus.rd = r; bus.wr = w; bus.addr = a; bus.wdata = wd;
        rx_status = rxs; rx_data = rxd;
        #1 d = bus.rdata;
        tick();
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        rx_status = 1'b0; rx_data = '0;
    endtask

    task automatic model_rx(input logic [7:0] b, input logic load, input logic popped);
        if (load) begin
            if (m_valid && !popped) m_ovr = 1'b1;
            m_byte  = b;
            m_valid = 1'b1;
        end else if (popped) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, w, exp_st;
        logic [7:0]  b;
        int          op, last_tx;

        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        rx_status = 1'b0; rx_data = '0;
        repeat (3) tick();
        check("reset_tx_en", {31'h0, tx_en}, 32'h0);
        check("reset_irq", {31'h0, irqout}, 32'h0);
        check("reset_tx_data", {24'h0, tx_data}, 32'h0);
        reset = 1'b1;
        tick();

        vecs[0]  = '{1'b1, 1'b0, STA,          32'h0,   1'b0, 8'h00, 32'h0000_0004};
        vecs[1]  = '{1'b1, 1'b0, BASE,         32'h0,   1'b0, 8'h00, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, BASE + 32'd12, 32'h0,  1'b0, 8'h00, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, BASE + 32'd9, 32'h0,   1'b0, 8'h00, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, STA,          32'h300, 1'b0, 8'h00, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, STA,          32'h0,   1'b0, 8'h00, 32'h0000_0304};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b1, 8'hA5, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, STA,          32'h0,   1'b0, 8'h00, 32'h0000_0305};
        vecs[8]  = '{1'b1, 1'b0, RXA,          32'h0,   1'b0, 8'h00, 32'h0000_00A5};
        vecs[9]  = '{1'b1, 1'b0, STA,          32'h0,   1'b0, 8'h00, 32'h0000_0304};
        vecs[10] = '{1'b0, 1'b1, STA,          32'hF0,  1'b0, 8'h00, 32'h0};
        vecs[11] = '{1'b1, 1'b0, STA,          32'h0,   1'b0, 8'h00, 32'h0000_0004};
        vecs[12] = '{1'b0, 1'b0, STA,          32'h0,   1'b0, 8'h00, 32'h0};
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rxs, vecs[i].rxd, d);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
        end
        tick();
        check("irq_after_vecs", {31'h0, irqout}, 32'h0);

        // Single byte: TX_EN two cycles after the write edge, busy until TX_STATUS falls.
        got_q.delete();
        cycle(1'b0, 1'b1, BASE, 32'h55, 1'b0, 8'h00, d);
        check("tx_en_lat0", {31'h0, tx_en}, 32'h0);
        tick();
        check("tx_en_lat1", {31'h0, tx_en}, 32'h0);
        tick();
        check("tx_en_lat2", {31'h0, tx_en}, 32'h1);
        check("tx_data_55", {24'h0, tx_data}, 32'h55);
        tx_hold = 1'b1;
        tick();
        check("tx_en_single", {31'h0, tx_en}, 32'h0);
        repeat (9) tick();
        cycle(1'b1, 1'b0, STA, 32'h0, 1'b0, 8'h00, d);
        check("tx_busy_held", d, 32'h0000_000C);
        tx_hold = 1'b0;
        tick();
        cycle(1'b1, 1'b0, STA, 32'h0, 1'b0, 8'h00, d);
        check("tx_busy_done", d, 32'h0000_0004);
        check("tx_one_frame", got_q.size(), 32'd1);

        // Overflow: six writes while uart_tx stays busy; 8'h06 is dropped.
        got_q.delete();
        tx_hold = 1'b1;
        for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b1, BASE, 32'(i), 1'b0, 8'h00, d);
        cycle(1'b1, 1'b0, STA, 32'h0, 1'b0, 8'h00, d);
        check("ovf_status", d, 32'h0000_002A);
        auto_tx = 1'b1;
        for (int c = 0; c < 300 && got_q.size() < 5; c++) tick();
        repeat (20) tick();
        check("ovf_count", got_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            check($sformatf("ovf_byte%0d", i), {24'h0, got_q[i]}, 32'(i + 1));
        cycle(1'b1, 1'b0, STA, 32'h0, 1'b0, 8'h00, d);
        check("ovf_sticky", d, 32'h0000_0024);
        cycle(1'b0, 1'b1, STA, 32'h20, 1'b0, 8'h00, d);
        cycle(1'b1, 1'b0, STA, 32'h0, 1'b0, 8'h00, d);
        check("ovf_cleared", d, 32'h0000_0004);

        // RX overrun.
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 8'hA3, d);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 8'h7E, d);
        tick(); tick();
        check("ovr_irq", {31'h0, irqout}, 32'h1);
        cycle(1'b1, 1'b0, RXA, 32'h0, 1'b0, 8'h00, d);
        check("ovr_byte", d, 32'h7E);
        cycle(1'b1, 1'b0, STA, 32'h0, 1'b0, 8'h00, d);
        check("ovr_status", d, 32'h0000_0014);
        cycle(1'b0, 1'b1, STA, 32'h10, 1'b0, 8'h00, d);
        cycle(1'b1, 1'b0, STA, 32'h0, 1'b0, 8'h00, d);
        check("ovr_cleared", d, 32'h0000_0004);
        tick();
        check("ovr_irq_off", {31'h0, irqout}, 32'h0);

        // New byte arriving on the same edge as the read of the previous one.
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 8'h22, d);
        cycle(1'b1, 1'b0, RXA, 32'h0, 1'b1, 8'h11, d);
        check("same_read_old", d, 32'h22);
        cycle(1'b1, 1'b0, STA, 32'h0, 1'b0, 8'h00, d);
        check("same_status", d, 32'h0000_0005);
        cycle(1'b1, 1'b0, RXA, 32'h0, 1'b0, 8'h00, d);
        check("same_new_byte", d, 32'h11);

`ifdef UART_RESP_LOOPBACK_EN
        got_q.delete();
        cycle(1'b0, 1'b1, STA, 32'h500, 1'b0, 8'h00, d);
        cycle(1'b0, 1'b1, BASE, 32'hC9, 1'b0, 8'h00, d);
        repeat (8) tick();
        check("lb_no_tx_en", got_q.size(), 32'd0);
        check("lb_irq", {31'h0, irqout}, 32'h1);
        cycle(1'b1, 1'b0, STA, 32'h0, 1'b0, 8'h00, d);
        check("lb_status", d, 32'h0000_0505);
        cycle(1'b1, 1'b0, RXA, 32'h0, 1'b0, 8'h00, d);
        check("lb_byte", d, 32'hC9);
        cycle(1'b0, 1'b1, STA, 32'h0, 1'b0, 8'h00, d);
`endif

        // Randomized phase from a known state.
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 8'h00, d);
        cycle(1'b1, 1'b0, RXA, 32'h0, 1'b0, 8'h00, d);
        check("rnd_sync", d, 32'h0);
        cycle(1'b0, 1'b1, STA, 32'h30, 1'b0, 8'h00, d);
        m_byte = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_rxen = 1'b0;
        got_q.delete();
        exp_q.delete();
        last_tx = -100;
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 5);
            b  = 8'($urandom);
            case (op)
                0: begin
                    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, b, d);
                    model_rx(b, 1'b1, 1'b0);
                end
                1: begin
                    cycle(1'b1, 1'b0, RXA, 32'h0, 1'b0, 8'h00, d);
                    check("rnd_rx_read", d, {24'h0, m_byte});
                    model_rx(8'h00, 1'b0, 1'b1);
                end
                2: begin
                    cycle(1'b1, 1'b0, RXA, 32'h0, 1'b1, b, d);
                    check("rnd_rx_read_load", d, {24'h0, m_byte});
                    model_rx(b, 1'b1, 1'b1);
                end
                3: begin
                    cycle(1'b1, 1'b0, STA, 32'h0, 1'b0, 8'h00, d);
                    exp_st = (32'(m_rxen) << 8) | (32'(m_ovr) << 4) | 32'(m_valid);
                    check("rnd_status", d & 32'hFFFF_FFF1, exp_st);
                end
                4: begin
                    w = $urandom & ~32'h0000_0600;
                    cycle(1'b0, 1'b1, STA, w, 1'b0, 8'h00, d);
                    m_rxen = w[8];
                    if (w[4]) m_ovr = 1'b0;
                end
                default: begin
                    if (it - last_tx >= 8) begin
                        cycle(1'b0, 1'b1, BASE, {24'h0, b}, 1'b0, 8'h00, d);
                        exp_q.push_back(b);
                        last_tx = it;
                    end else begin
                        tick();
                    end
                end
            endcase
            tick();
            check("rnd_irq", {31'h0, irqout}, {31'h0, (m_rxen && m_valid) || m_ovr});
        end
        for (int c = 0; c < 200 && got_q.size() < exp_q.size(); c++) tick();
        check("rnd_tx_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rnd_tx_byte%0d", i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
- Memory-mapped UART controller that answers CPU data-bus accesses (rd/wr/addr/wdata, MEM stage).
- Buffers CPU bytes in a TX FIFO and drives the uart_tx handshake.
- Captures uart_rx bytes into a holding register.
- Raises a level interrupt into the CPU's IRQ path.

Parameters:
- BASE_ADDR, 32'h4000_0018: byte address of TXDATA. RXDATA is BASE+4. STATUS/CTRL is BASE+8.
- TX_DEPTH, 4: TX FIFO entries. Power of two, ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rd  in  1  bus read strobe, one cycle per access
- wr  in  1  bus write strobe, one cycle per access
- addr  in  32  bus byte address. Only word-aligned exact matches to the three registers respond.
- wdata  in  32  write data
- rdata  out  32  read data, combinational
- irqout  out  1  level interrupt
- TX_EN  out  1  one-cycle start pulse to uart_tx
- TX_DATA  out  8  byte to uart_tx, stable from TX_EN until transmission ends
- TX_STATUS  in  1  uart_tx active flag
- RX_STATUS  in  1  uart_rx data-valid, one-cycle pulse
- RX_DATA  in  8  uart_rx byte, valid with RX_STATUS

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty; rx_valid=0; all sticky flags 0; irq enables 0; TX FSM in IDLE.
- Reset output values: TX_EN=0, TX_DATA=0, irqout=0. rdata follows its combinational rule with cleared state.
- Reset mid-transmission abandons the FSM. uart_tx finishes on its own; there is no recovery handshake.
- rdata, combinational:
  - rd & addr==BASE+4 → {24'b0, rx_byte}
  - rd & addr==BASE+8 → status word
  - otherwise 0
  - TXDATA reads 0.
- Status word bits:
  - [0] rx_valid
  - [1] tx_full
  - [2] tx_empty
  - [3] tx_busy (FSM≠IDLE)
  - [4] rx_overrun, sticky
  - [5] tx_overflow, sticky
  - [8] rx_irq_en
  - [9] tx_irq_en
  - [10] loopback (see Optional Feature)
  - other bits 0
- Writes:
  - wr & BASE: push wdata[7:0] if not full at the clock edge. If full, the byte is dropped and tx_overflow is set. A same-cycle FSM pop does not make room for the push.
  - wr & BASE+8: write-1-to-clear on [5:4]; load [9:8] (and [10] when enabled).
- RX path:
  - RX_STATUS loads rx_byte and sets rx_valid.
  - If rx_valid is already 1 and no same-cycle pop: overwrite the byte and set rx_overrun.
  - rd & BASE+4 clears rx_valid on the edge.
  - RX_STATUS and pop in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
- TX FSM:
  - IDLE: FIFO non-empty → LAUNCH.
  - LAUNCH: pop head into TX_DATA, TX_EN=1 for this single cycle → WAIT_BUSY.
  - WAIT_BUSY: TX_STATUS=1 → WAIT_DONE.
  - WAIT_DONE: TX_STATUS=0 → IDLE.
  - Back-to-back FIFO bytes cost 2 idle cycles between frames (WAIT_DONE→IDLE→LAUNCH).
  - Latency from the wr edge into an empty FIFO to TX_EN high: 2 cycles.
- irqout = (rx_irq_en & rx_valid) | (tx_irq_en & tx_empty & ~tx_busy) | rx_overrun. Registered.
- FIFO pointers are log2(TX_DEPTH)+1 bits; wrap-around via the MSB compare.

Optional Feature:
- Macro UART_RESP_LOOPBACK_EN.
- Defined:
  - CTRL bit [10] is read/write.
  - When bit [10]=1, LAUNCH suppresses TX_EN and writes the popped byte into the RX path as if RX_STATUS had fired, including the overrun rules.
  - The FSM then returns directly to IDLE.
  - External RX_STATUS is ignored while loopback=1.
- Undefined: bit [10] reads 0, its writes are ignored, and no loopback logic is built.

Decomposition:
- Package uart_resp_pkg holds:
  - register offsets TXDATA_OFF=0, RXDATA_OFF=4, STAT_OFF=8
  - status bit index constants
  - TX FSM state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, 2 bits)
- One sub-module: sync_fifo (width 8, depth TX_DEPTH, push/pop/full/empty, same clk/reset).

Test Plan:
- Reset check → TX_EN=0, irqout=0, and a STATUS read returns 32'h0000_0004.
- Write 8'h55 to BASE, then model uart_tx with TX_STATUS high for 10 cycles → TX_EN pulses exactly 2 cycles after the write with TX_DATA=8'h55; tx_busy=1 until TX_STATUS falls.
- Write 5 bytes 8'h01..8'h05 while TX_STATUS is held high (TX_DEPTH=4) → the FSM holds 8'h01 (WAIT_BUSY) while the FIFO fills with 8'h02..8'h05. The 6th write, 8'h06, is dropped and tx_overflow=1. Bytes emit in order 8'h01..8'h05.
- RX_STATUS with 8'hA3, then RX_STATUS with 8'h7E, no read → read BASE+4 returns 8'h7E; STATUS bit4=1 and irqout=1. Write 32'h10 to STATUS → bit4 clears.
- RX_STATUS with 8'h11 in the same cycle as an RXDATA read of the prior byte 8'h22 → the read returns 8'h22; rx_valid stays 1 holding 8'h11; overrun=0.
- With UART_RESP_LOOPBACK_EN and CTRL=32'h500, write 8'hC9 → TX_EN is never asserted; rx_valid=1 with 8'hC9; irqout=1.
